// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared state encoding and transfer constants for the SHA-256 host sequencer
package sha256_pkg;
  localparam int BLK_HW   = 32;
  localparam int DIG_HW   = 16;
  localparam bit HI_FIRST = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT_WORD,
    S_LOAD_HI,
    S_LOAD_LO,
    S_FETCH,
    S_DONE,
    S_ERR
  } state_e;
endpackage

// File: rtl/sha256_host_sequencer_req.sv
// rtl/sha256_host_sequencer_req.sv - generic four-phase requester with ack timeout
module sha256_4ph_req #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic ack,
  output logic req,
  output logic ack_rise,
  output logic hs_done,
  output logic timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic          rel_q, rel_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rel_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      rel_q <= rel_d;
      cnt_q <= cnt_d;
    end
  end

  // The wait counter restarts at each phase change, so every ack edge gets a full budget.
  always_comb begin
    rel_d    = rel_q;
    cnt_d    = cnt_q;
    req      = 1'b0;
    ack_rise = 1'b0;
    hs_done  = 1'b0;
    timeout  = 1'b0;
    if (!en) begin
      rel_d = 1'b0;
      cnt_d = '0;
    end else if (!rel_q) begin
      req = 1'b1;
      if (ack) begin
        ack_rise = 1'b1;
        rel_d    = 1'b1;
        cnt_d    = '0;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        timeout = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      if (!ack) begin
        hs_done = 1'b1;
        rel_d   = 1'b0;
        cnt_d   = '0;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        timeout = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sha256_host_sequencer.sv
// rtl/sha256_host_sequencer.sv - streams message words into the SHA-256 core and reads back the digest
module sha256_host_sequencer
  import sha256_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        msg_valid,
  input  logic [31:0] msg_data,
  input  logic        msg_last,
  output logic        msg_ready,
  output logic        sha_init,
  output logic        sha_load,
  output logic        sha_fetch,
  output logic [15:0] sha_idata,
  input  logic        sha_ack,
  input  logic [15:0] sha_odata,
  output logic        dig_valid,
  output logic [15:0] dig_data,
  output logic [3:0]  dig_idx,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int HW_W = $clog2(BLK_HW);

  state_e            state_q, state_d;
  logic [HW_W-1:0]   hw_cnt_q, hw_cnt_d;
  logic [3:0]        dig_cnt_q, dig_cnt_d;
  logic              final_q, final_d;
  logic [31:0]       hold_q, hold_d;
  logic              dig_valid_q, dig_valid_d;
  logic [15:0]       dig_data_q, dig_data_d;
  logic [3:0]        dig_idx_q, dig_idx_d;
  logic              req_en, req, req_ack, req_done, req_to;
  logic [15:0]       first_hw, second_hw;

  sha256_4ph_req #(.TIMEOUT(ACK_TIMEOUT)) u_req (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (req_en),
    .ack      (sha_ack),
    .req      (req),
    .ack_rise (req_ack),
    .hs_done  (req_done),
    .timeout  (req_to)
  );

  assign req_en    = (state_q == S_LOAD_HI) || (state_q == S_LOAD_LO) || (state_q == S_FETCH);
  assign first_hw  = HI_FIRST ? hold_q[31:16] : hold_q[15:0];
  assign second_hw = HI_FIRST ? hold_q[15:0]  : hold_q[31:16];
  assign busy      = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign dig_valid = dig_valid_q;
  assign dig_data  = dig_data_q;
  assign dig_idx   = dig_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hw_cnt_q    <= '0;
      dig_cnt_q   <= '0;
      final_q     <= 1'b0;
      hold_q      <= '0;
      dig_valid_q <= 1'b0;
      dig_data_q  <= '0;
      dig_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      hw_cnt_q    <= hw_cnt_d;
      dig_cnt_q   <= dig_cnt_d;
      final_q     <= final_d;
      hold_q      <= hold_d;
      dig_valid_q <= dig_valid_d;
      dig_data_q  <= dig_data_d;
      dig_idx_q   <= dig_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hw_cnt_d    = hw_cnt_q;
    dig_cnt_d   = dig_cnt_q;
    final_d     = final_q;
    hold_d      = hold_q;
    dig_valid_d = 1'b0;
    dig_data_d  = dig_data_q;
    dig_idx_d   = dig_idx_q;
    msg_ready   = 1'b0;
    sha_init    = 1'b0;
    sha_load    = 1'b0;
    sha_fetch   = 1'b0;
    sha_idata   = '0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d   = S_INIT;
          hw_cnt_d  = '0;
          dig_cnt_d = '0;
          final_d   = 1'b0;
        end
      end
      S_INIT: begin
        sha_init = 1'b1;
        state_d  = S_WAIT_WORD;
      end
      S_WAIT_WORD: begin
        msg_ready = 1'b1;
        if (msg_valid) begin
          hold_d  = msg_data;
          final_d = final_q | msg_last;
          state_d = S_LOAD_HI;
        end
      end
      S_LOAD_HI: begin
        sha_load  = req;
        sha_idata = first_hw;
        if (req_to) begin
          state_d = S_ERR;
        end else if (req_done) begin
          hw_cnt_d = hw_cnt_q + 1'b1;
          state_d  = S_LOAD_LO;
        end
      end
      S_LOAD_LO: begin
        sha_load  = req;
        sha_idata = second_hw;
        if (req_to) begin
          state_d = S_ERR;
        end else if (req_done) begin
          hw_cnt_d = hw_cnt_q + 1'b1;
          // A full non-final block simply rolls into the next one without re-init.
          state_d  = ((hw_cnt_q == HW_W'(BLK_HW - 1)) && final_q) ? S_FETCH : S_WAIT_WORD;
        end
      end
      S_FETCH: begin
        sha_fetch = req;
        if (req_ack) begin
          dig_valid_d = 1'b1;
          dig_data_d  = sha_odata;
          dig_idx_d   = dig_cnt_q;
        end
        if (req_to) begin
          state_d = S_ERR;
        end else if (req_done) begin
          dig_cnt_d = dig_cnt_q + 1'b1;
          state_d   = (dig_cnt_q == 4'(DIG_HW - 1)) ? S_DONE : S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule
